// File: rtl/countdown_timer_pkg.sv
// Shared constants, state encoding and duration clamp used by the
// countdown timer and its display/control neighbours.
package countdown_timer_pkg;

    localparam int unsigned MIN_SEC     = 5;
    localparam int unsigned MAX_SEC     = 15;
    localparam int unsigned DEFAULT_SEC = 10;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic logic [7:0] clamp_sec(input logic [7:0] sec,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
        if (sec < lo) return lo;
        if (sec > hi) return hi;
        return sec;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/display-facing signal bundle of the countdown timer.
interface countdown_timer_if;

    logic       cfg_valid;
    logic [7:0] cfg_sec;
    logic       start;
    logic       cancel;
    logic [7:0] countdown_val;
    logic       active;
    logic       timeout;
    logic [7:0] cfg_sec_q;

    modport master (
        output cfg_valid, cfg_sec, start, cancel,
        input  countdown_val, active, timeout, cfg_sec_q
    );

    modport slave (
        input  cfg_valid, cfg_sec, start, cancel,
        output countdown_val, active, timeout, cfg_sec_q
    );

endinterface

// File: rtl/countdown_timer_tick_gen.sv
// One-second prescaler: tick is high in the cycle the count equals CLK_FREQ-1.
module tick_gen #(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_FREQ - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown with clamped configurable duration, restart/cancel
// control and a one-cycle timeout pulse on natural expiry.
module countdown_timer #(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned MIN_SEC     = countdown_timer_pkg::MIN_SEC,
    parameter int unsigned MAX_SEC     = countdown_timer_pkg::MAX_SEC,
    parameter int unsigned DEFAULT_SEC = countdown_timer_pkg::DEFAULT_SEC
) (
    input  logic               clk,
    input  logic               rst_n,
    countdown_timer_if.slave   bus
);

    import countdown_timer_pkg::*;

    localparam logic [7:0] LO  = 8'(MIN_SEC);
    localparam logic [7:0] HI  = 8'(MAX_SEC);
    localparam logic [7:0] DEF = 8'(DEFAULT_SEC);

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       active_q, active_d;
    logic       timeout_q, timeout_d;
    logic [7:0] cfg_q, cfg_d;
    logic [7:0] cfg_clamped;
    logic [7:0] eff_sec;
    logic       clr;
    logic       tick;

    tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    // A config strobe coinciding with start takes effect for that start.
    assign cfg_clamped = clamp_sec(bus.cfg_sec, LO, HI);
    assign eff_sec     = bus.cfg_valid ? cfg_clamped : cfg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            active_q  <= 1'b0;
            timeout_q <= 1'b0;
            cfg_q     <= DEF;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            active_q  <= active_d;
            timeout_q <= timeout_d;
            cfg_q     <= cfg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        active_d  = active_q;
        timeout_d = 1'b0;
        cfg_d     = bus.cfg_valid ? cfg_clamped : cfg_q;
        clr       = 1'b0;
        unique case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (bus.start) begin
                    state_d  = RUN;
                    count_d  = eff_sec;
                    active_d = 1'b1;
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_d  = IDLE;
                    count_d  = '0;
                    active_d = 1'b0;
                    clr      = 1'b1;
                end else if (bus.start) begin
                    count_d = eff_sec;
                    clr     = 1'b1;
                end else if (tick) begin
                    if (count_q > 8'd1) begin
                        count_d = count_q - 8'd1;
                    end else begin
                        state_d   = IDLE;
                        count_d   = '0;
                        active_d  = 1'b0;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.countdown_val = count_q;
    assign bus.active        = active_q;
    assign bus.timeout       = timeout_q;
    assign bus.cfg_sec_q     = cfg_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer at CLK_FREQ=10.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    countdown_timer_if bus();

    countdown_timer #(.CLK_FREQ(10)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic cv, input logic [7:0] sec);
        bus.start = 1'b1; bus.cfg_valid = cv; bus.cfg_sec = sec;
        step(1);
        bus.start = 1'b0; bus.cfg_valid = 1'b0;
    endtask

    task automatic do_cfg(input logic [7:0] sec);
        bus.cfg_valid = 1'b1; bus.cfg_sec = sec;
        step(1);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        bus.cfg_valid = 1'b0; bus.cfg_sec = '0; bus.start = 1'b0; bus.cancel = 1'b0;
        rst_n = 1'b0;
        step(2);
        checks++; if (bus.countdown_val !== 8'd0) begin errors++; $display("FAIL rst_hold_val got=%0d exp=0", bus.countdown_val); end
        rst_n = 1'b1;
        step(1);
        checks++; if (bus.countdown_val !== 8'd0) begin errors++; $display("FAIL rst_val got=%0d exp=0", bus.countdown_val); end
        checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL rst_active got=%b exp=0", bus.active); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%b exp=0", bus.timeout); end
        checks++; if (bus.cfg_sec_q !== 8'd10) begin errors++; $display("FAIL rst_cfg got=%0d exp=10", bus.cfg_sec_q); end
    endtask

    task automatic test_nominal;
        pulse_start(1'b0, 8'd0);
        checks++; if (bus.countdown_val !== 8'd10) begin errors++; $display("FAIL nom_load got=%0d exp=10", bus.countdown_val); end
        checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL nom_active got=%b exp=1", bus.active); end
        step(9);
        checks++; if (bus.countdown_val !== 8'd10) begin errors++; $display("FAIL nom_t9 got=%0d exp=10", bus.countdown_val); end
        step(1);
        checks++; if (bus.countdown_val !== 8'd9) begin errors++; $display("FAIL nom_t10 got=%0d exp=9", bus.countdown_val); end
        step(80);
        checks++; if (bus.countdown_val !== 8'd1) begin errors++; $display("FAIL nom_t90 got=%0d exp=1", bus.countdown_val); end
        step(9);
        checks++; if (bus.timeout !== 1'b0 || bus.countdown_val !== 8'd1) begin errors++; $display("FAIL nom_t99 got=%0d/%b exp=1/0", bus.countdown_val, bus.timeout); end
        step(1);
        checks++; if (bus.countdown_val !== 8'd0) begin errors++; $display("FAIL nom_t100_val got=%0d exp=0", bus.countdown_val); end
        checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL nom_t100_active got=%b exp=0", bus.active); end
        checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL nom_t100_timeout got=%b exp=1", bus.timeout); end
        step(1);
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL nom_t101_timeout got=%b exp=0", bus.timeout); end
    endtask

    task automatic test_clamp;
        logic [7:0] req [7] = '{8'd3, 8'd20, 8'd12, 8'd0, 8'd255, 8'd5, 8'd15};
        logic [7:0] exp [7] = '{8'd5, 8'd15, 8'd12, 8'd5, 8'd15,  8'd5, 8'd15};
        for (int i = 0; i < 7; i++) begin
            do_cfg(req[i]);
            checks++;
            if (bus.cfg_sec_q !== exp[i]) begin
                errors++; $display("FAIL clamp_%0d got=%0d exp=%0d", req[i], bus.cfg_sec_q, exp[i]);
            end
        end
        pulse_start(1'b1, 8'd7);
        checks++; if (bus.countdown_val !== 8'd7) begin errors++; $display("FAIL cfg_with_start got=%0d exp=7", bus.countdown_val); end
        checks++; if (bus.cfg_sec_q !== 8'd7) begin errors++; $display("FAIL cfg_with_start_q got=%0d exp=7", bus.cfg_sec_q); end
    endtask

    task automatic test_cancel;
        int unsigned seen = 0;
        bus.cancel = 1'b1;
        step(1);
        bus.cancel = 1'b0;
        checks++; if (bus.countdown_val !== 8'd0) begin errors++; $display("FAIL cancel_val got=%0d exp=0", bus.countdown_val); end
        checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL cancel_active got=%b exp=0", bus.active); end
        for (int i = 0; i < 100; i++) begin
            if (bus.timeout === 1'b1) seen++;
            step(1);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL cancel_no_timeout got=%0d pulses exp=0", seen); end
        pulse_start(1'b0, 8'd0);
        checks++; if (bus.countdown_val !== 8'd7) begin errors++; $display("FAIL cancel_restart got=%0d exp=7", bus.countdown_val); end
        bus.start = 1'b1; bus.cancel = 1'b1;
        step(1);
        bus.start = 1'b0; bus.cancel = 1'b0;
        checks++; if (bus.countdown_val !== 8'd0 || bus.active !== 1'b0) begin errors++; $display("FAIL cancel_beats_start got=%0d/%b exp=0/0", bus.countdown_val, bus.active); end
        step(15);
        checks++; if (bus.countdown_val !== 8'd0 || bus.active !== 1'b0) begin errors++; $display("FAIL cancel_stays_idle got=%0d/%b exp=0/0", bus.countdown_val, bus.active); end
    endtask

    task automatic test_restart;
        do_cfg(8'd10);
        pulse_start(1'b0, 8'd0);
        step(60);
        checks++; if (bus.countdown_val !== 8'd4) begin errors++; $display("FAIL rs_pre got=%0d exp=4", bus.countdown_val); end
        pulse_start(1'b0, 8'd0);
        checks++; if (bus.countdown_val !== 8'd10) begin errors++; $display("FAIL rs_reload got=%0d exp=10", bus.countdown_val); end
        step(9);
        checks++; if (bus.countdown_val !== 8'd10) begin errors++; $display("FAIL rs_t9 got=%0d exp=10", bus.countdown_val); end
        step(1);
        checks++; if (bus.countdown_val !== 8'd9) begin errors++; $display("FAIL rs_t10 got=%0d exp=9", bus.countdown_val); end
        do_cfg(8'd6);
        checks++; if (bus.countdown_val !== 8'd9) begin errors++; $display("FAIL rs_cfg_run_val got=%0d exp=9", bus.countdown_val); end
        checks++; if (bus.cfg_sec_q !== 8'd6) begin errors++; $display("FAIL rs_cfg_run_q got=%0d exp=6", bus.cfg_sec_q); end
        step(8);
        checks++; if (bus.countdown_val !== 8'd9) begin errors++; $display("FAIL rs_t19 got=%0d exp=9", bus.countdown_val); end
        step(1);
        checks++; if (bus.countdown_val !== 8'd8) begin errors++; $display("FAIL rs_t20 got=%0d exp=8", bus.countdown_val); end
        bus.cancel = 1'b1;
        step(1);
        bus.cancel = 1'b0;
        pulse_start(1'b0, 8'd0);
        checks++; if (bus.countdown_val !== 8'd6 || bus.active !== 1'b1) begin errors++; $display("FAIL rs_next_load got=%0d/%b exp=6/1", bus.countdown_val, bus.active); end
    endtask

    task automatic test_reset_midrun;
        int unsigned seen = 0;
        pulse_start(1'b1, 8'd12);
        checks++; if (bus.countdown_val !== 8'd12) begin errors++; $display("FAIL rm_load got=%0d exp=12", bus.countdown_val); end
        step(40);
        checks++; if (bus.countdown_val !== 8'd8) begin errors++; $display("FAIL rm_pre got=%0d exp=8", bus.countdown_val); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.countdown_val !== 8'd0) begin errors++; $display("FAIL rm_async_val got=%0d exp=0", bus.countdown_val); end
        checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL rm_async_active got=%b exp=0", bus.active); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL rm_async_timeout got=%b exp=0", bus.timeout); end
        checks++; if (bus.cfg_sec_q !== 8'd10) begin errors++; $display("FAIL rm_async_cfg got=%0d exp=10", bus.cfg_sec_q); end
        step(3);
        rst_n = 1'b1;
        for (int i = 0; i < 120; i++) begin
            step(1);
            if (bus.timeout === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rm_no_timeout got=%0d pulses exp=0", seen); end
        checks++; if (bus.cfg_sec_q !== 8'd10) begin errors++; $display("FAIL rm_cfg_after got=%0d exp=10", bus.cfg_sec_q); end
        checks++; if (bus.countdown_val !== 8'd0 || bus.active !== 1'b0) begin errors++; $display("FAIL rm_idle_after got=%0d/%b exp=0/0", bus.countdown_val, bus.active); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_clamp();
        test_cancel();
        test_restart();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
